// File: rtl/alu_scheduler_if.sv
// alu_scheduler_if -- request/response bundle between the control front-end
// and alu_scheduler.
//   req_valid[1:0]     requester i presents an operation on bit i
//   req_ready[1:0]     scheduler accepts requester i (one-hot or zero)
//   reqN_a/b, reqN_uc  operands and ALU opcode of requester N
//   rsp_valid/ready    response handshake (held until consumed)
//   rsp_id             requester that issued the operation
//   rsp_result         ALU result
//   rsp_n/z/c/v/err    ALU flags and illegal-opcode indication
// master = front-end/consumer side, slave = scheduler side.
interface alu_scheduler_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [3:0]       req0_uc;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [3:0]       req1_uc;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_n;
  logic             rsp_z;
  logic             rsp_c;
  logic             rsp_v;
  logic             rsp_err;

  modport master (
    output req_valid, req0_a, req0_b, req0_uc, req1_a, req1_b, req1_uc, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_err
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_uc, req1_a, req1_b, req1_uc, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_err
  );
endinterface

// File: rtl/alu_scheduler.sv
// alu_scheduler -- shares one combinational ALU between two requesters.
// Round-robin arbitration in IDLE, one EXEC cycle through the ALU, then the
// result is held in RESP until the consumer takes it.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   alu_scheduler_if.slave (request ports, response port)
// Opcodes: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 and, 6 or, 7 xor, 8 shl;
// anything above 8 is illegal (result 0, z=1, rsp_err=1).

// Combinational ALU shared by the scheduler.
module alu #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       uc,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    result = '0;
    n      = 1'b0;
    c      = 1'b0;
    v      = 1'b0;
    case (uc)
      4'd0: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
      end
      4'd1: begin
        // Sign-magnitude difference: n flags the borrow.
        if (a < b) begin
          result = b - a;
          n      = 1'b1;
        end else begin
          result = a - b;
        end
      end
      4'd2: begin
        result = prod[WIDTH-1:0];
        c      = prod[WIDTH];
        v      = (32'(prod) > 32'd31);
      end
      4'd3:    result = (b == '0) ? '0 : a / b;
      4'd4:    result = (b == '0) ? '0 : a % b;
      4'd5:    result = a & b;
      4'd6:    result = a | b;
      4'd7:    result = a ^ b;
      4'd8:    result = a << b;
      default: result = '0;
    endcase
    z = (result == '0);
  end
endmodule

module alu_scheduler #(
  parameter int WIDTH = 4
) (
  input logic            clk,
  input logic            rst,
  alu_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             ptr;        // requester that wins the next tie
  logic             gnt_id;
  logic             accept;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_uc;
  logic             op_id;

  logic [WIDTH-1:0] alu_result;
  logic             alu_n, alu_z, alu_c, alu_v;

  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_n_q, rsp_z_q, rsp_c_q, rsp_v_q, rsp_err_q;

  // A lone requester wins outright; on a tie the pointer decides.
  always_comb begin
    gnt_id = bus.req_valid[1];
    if (bus.req_valid == 2'b11) gnt_id = ptr;
  end

  // Ready is only offered in IDLE so nothing is accepted while an operation
  // or an unconsumed response is in flight; reset masks it as well.
  assign accept        = (state == IDLE) && !rst && (|bus.req_valid);
  assign bus.req_ready = accept ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

  // NOTE: operand registers are pure datapath, loaded before they are ever
  // read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a  <= gnt_id ? bus.req1_a  : bus.req0_a;
      op_b  <= gnt_id ? bus.req1_b  : bus.req0_b;
      op_uc <= gnt_id ? bus.req1_uc : bus.req0_uc;
      op_id <= gnt_id;
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .uc     (op_uc),
    .result (alu_result),
    .n      (alu_n),
    .z      (alu_z),
    .c      (alu_c),
    .v      (alu_v)
  );

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_n_q      <= 1'b0;
      rsp_z_q      <= 1'b0;
      rsp_c_q      <= 1'b0;
      rsp_v_q      <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ptr   <= ~gnt_id;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid_q  <= 1'b1;
          rsp_id_q     <= op_id;
          rsp_result_q <= alu_result;
          rsp_n_q      <= alu_n;
          rsp_z_q      <= alu_z;
          rsp_c_q      <= alu_c;
          rsp_v_q      <= alu_v;
          rsp_err_q    <= (op_uc > 4'b1000);
          state        <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_n      = rsp_n_q;
  assign bus.rsp_z      = rsp_z_q;
  assign bus.rsp_c      = rsp_c_q;
  assign bus.rsp_v      = rsp_v_q;
  assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: a transaction-level model (busy flag,
// cycles since accept, pending/held response) is compared with the DUT on
// every falling edge; directed scenarios add literal expectations.
module tb_alu_scheduler;
  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] r;
    logic n, z, c, v, err, id;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_scheduler_if #(.WIDTH(W)) bus();
  alu_scheduler #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the opcode definitions, plain integer arithmetic.
  function automatic rsp_t alu_model(input int a, input int b, input int uc, input logic id);
    rsp_t o;
    int   s;
    o = '0;
    o.id = id;
    case (uc)
      0: begin s = a + b; o.r = W'(s % (1 << W)); o.c = (s >= (1 << W)); end
      1: begin
        if (a >= b) o.r = W'(a - b);
        else begin o.r = W'(b - a); o.n = 1'b1; end
      end
      2: begin
        s = a * b;
        o.r = W'(s % (1 << W));
        o.c = ((s / (1 << W)) % 2) == 1;
        o.v = (s > 31);
      end
      3: o.r = (b == 0) ? '0 : W'(a / b);
      4: o.r = (b == 0) ? '0 : W'(a % b);
      5: o.r = W'(a & b);
      6: o.r = W'(a | b);
      7: o.r = W'(a ^ b);
      8: o.r = W'((a << b) % (1 << W));
      default: begin o.r = '0; o.err = 1'b1; end
    endcase
    o.z = (o.r == '0);
    return o;
  endfunction

  // Model state.
  bit   armed = 0;
  bit   m_busy;
  int   m_age;
  logic m_ptr;
  rsp_t m_pend, m_last;
  logic [1:0] acc = 2'b00;
  int   cyc = 0;
  int   acc_id_log[$];
  int   acc_cyc_log[$];

  always @(negedge clk) begin
    logic [1:0] exp_ready;
    logic       win;
    rsp_t       o;
    win = bus.req_valid[1];
    if (bus.req_valid == 2'b11) win = m_ptr;
    if (armed) begin
      exp_ready = 2'b00;
      if (!rst && !m_busy && (|bus.req_valid)) exp_ready[win] = 1'b1;
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_busy && m_age >= 2));
      o = {bus.rsp_result, bus.rsp_n, bus.rsp_z, bus.rsp_c, bus.rsp_v, bus.rsp_err, bus.rsp_id};
      check("rsp_result", 32'(o.r), 32'(m_last.r));
      check("rsp_flags_nzcv", 32'({o.n, o.z, o.c, o.v}), 32'({m_last.n, m_last.z, m_last.c, m_last.v}));
      check("rsp_err", 32'(o.err), 32'(m_last.err));
      check("rsp_id", 32'(o.id), 32'(m_last.id));
    end
    acc = bus.req_valid & bus.req_ready;
    // Advance the model across the coming rising edge.
    if (rst) begin
      armed  = 1;
      m_busy = 0;
      m_age  = 0;
      m_ptr  = 1'b0;
      m_last = '0;
    end else if (armed) begin
      if (!m_busy) begin
        if (|bus.req_valid) begin
          m_busy = 1;
          m_age  = 1;
          m_pend = win ? alu_model(int'(bus.req1_a), int'(bus.req1_b), int'(bus.req1_uc), 1'b1)
                       : alu_model(int'(bus.req0_a), int'(bus.req0_b), int'(bus.req0_uc), 1'b0);
          m_ptr  = ~win;
          acc_id_log.push_back(int'(win));
          acc_cyc_log.push_back(cyc);
        end
      end else if (m_age == 1) begin
        m_last = m_pend;
        m_age  = 2;
      end else if (bus.rsp_ready) begin
        m_busy = 0;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request on one port and hold it until granted (bounded).
  task automatic issue(input int id, input int a, input int b, input int uc);
    bit ok;
    ok = 0;
    if (id == 0) begin
      bus.req0_a = W'(a); bus.req0_b = W'(b); bus.req0_uc = 4'(uc);
    end else begin
      bus.req1_a = W'(a); bus.req1_b = W'(b); bus.req1_uc = 4'(uc);
    end
    bus.req_valid[id] = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk);
      if (acc[id]) ok = 1;
      #1;
    end
    bus.req_valid[id] = 1'b0;
    if (!ok) check("grant_timeout", 32'd0, 32'd1);
  endtask

  // Wait (bounded) for rsp_valid, sampling at the falling edge.
  task automatic wait_rsp();
    bit ok;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid === 1'b1) ok = 1;
    end
    if (!ok) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rsp_t t;
    bus.req_valid = 2'b00;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_uc = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_uc = '0;
    bus.rsp_ready = 1'b1;

    // Pin the reference model with hand-computed values.
    t = alu_model(3, 5, 0, 1'b0); check("model_add", 32'(t), 32'({4'd8, 6'b000000}));
    t = alu_model(3, 5, 1, 1'b1); check("model_sub", 32'(t), 32'({4'd2, 6'b100001}));
    t = alu_model(7, 5, 2, 1'b1); check("model_mul", 32'(t), 32'({4'd3, 6'b000101}));
    t = alu_model(9, 2, 11, 1'b0); check("model_illegal", 32'(t), 32'({4'd0, 6'b010010}));
    t = alu_model(6, 0, 3, 1'b0); check("model_div0", 32'(t), 32'({4'd0, 6'b010000}));

    // 1. Reset then idle.
    tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    repeat (10) tick();
    @(negedge clk); #1;
    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("idle_req_ready", 32'(bus.req_ready), 32'd0);
    check("idle_result", 32'(bus.rsp_result), 32'd0);
    tick();

    // 2. Single add on requester 0.
    issue(0, 3, 5, 0);
    wait_rsp();
    check("add_result", 32'(bus.rsp_result), 32'd8);
    check("add_id", 32'(bus.rsp_id), 32'd0);
    check("add_flags", 32'({bus.rsp_n, bus.rsp_z, bus.rsp_c, bus.rsp_v, bus.rsp_err}), 32'd0);
    tick();

    // 3. Sub and mul on requester 1.
    issue(1, 3, 5, 1);
    wait_rsp();
    check("sub_result", 32'(bus.rsp_result), 32'd2);
    check("sub_n_c", 32'({bus.rsp_n, bus.rsp_c}), 32'b10);
    check("sub_id", 32'(bus.rsp_id), 32'd1);
    tick();
    issue(1, 7, 5, 2);
    wait_rsp();
    check("mul_result", 32'(bus.rsp_result), 32'd3);
    check("mul_v_c", 32'({bus.rsp_v, bus.rsp_c}), 32'b10);
    tick();

    // 4. Round-robin with both requesters always valid.
    acc_id_log.delete();
    acc_cyc_log.delete();
    bus.req0_a = 4'd1; bus.req0_b = 4'd2; bus.req0_uc = 4'd0;
    bus.req1_a = 4'd9; bus.req1_b = 4'd4; bus.req1_uc = 4'd1;
    bus.req_valid = 2'b11;
    repeat (24) tick();
    bus.req_valid = 2'b00;
    repeat (4) tick();
    check("rr_count_ge_7", 32'(acc_id_log.size() >= 7), 32'd1);
    if (acc_id_log.size() > 0) check("rr_first", 32'(acc_id_log[0]), 32'd0);
    for (int k = 1; k < acc_id_log.size(); k++) begin
      check("rr_alternate", 32'(acc_id_log[k]), 32'(1 - acc_id_log[k-1]));
      check("rr_spacing", 32'(acc_cyc_log[k] - acc_cyc_log[k-1]), 32'd3);
    end

    // 5. Back-pressure with an illegal opcode; requester 1 waits meanwhile.
    bus.rsp_ready = 1'b0;
    issue(0, 9, 2, 11);
    bus.req1_a = 4'd2; bus.req1_b = 4'd2; bus.req1_uc = 4'd0;
    bus.req_valid[1] = 1'b1;
    wait_rsp();
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_result_z_err", 32'({bus.rsp_result, bus.rsp_z, bus.rsp_err}), 32'({4'd0, 2'b11}));
      @(negedge clk); #1;
    end
    bus.req_valid[1] = 1'b0;
    tick();
    bus.rsp_ready = 1'b1;
    tick();
    @(negedge clk); #1;
    check("bp_release", 32'(bus.rsp_valid), 32'd0);
    tick();

    // 6. Division by zero, then reset during EXEC of a re-issue.
    issue(0, 6, 0, 3);
    wait_rsp();
    check("div0_result", 32'(bus.rsp_result), 32'd0);
    check("div0_z", 32'(bus.rsp_z), 32'd1);
    tick();
    issue(0, 6, 0, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk); #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_outputs", 32'({bus.rsp_result, bus.rsp_n, bus.rsp_z, bus.rsp_c, bus.rsp_v, bus.rsp_err, bus.rsp_id}), 32'd0);
    tick();
    bus.req_valid = 2'b11;
    @(negedge clk); #1;
    check("rst_ptr_tie", 32'(bus.req_ready), 32'b01);
    tick();
    bus.req_valid = 2'b00;
    repeat (4) tick();

    // 7. Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!bus.req_valid[i] || acc[i]) begin
          if ($urandom_range(2) != 0) begin
            if (i == 0) begin
              bus.req0_a = W'($urandom); bus.req0_b = W'($urandom); bus.req0_uc = 4'($urandom_range(11));
            end else begin
              bus.req1_a = W'($urandom); bus.req1_b = W'($urandom); bus.req1_uc = 4'($urandom_range(11));
            end
            bus.req_valid[i] = 1'b1;
          end else begin
            bus.req_valid[i] = 1'b0;
          end
        end else if ($urandom_range(15) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom_range(3) != 0);
      if ($urandom_range(199) == 0) rst = 1'b1;
      else rst = 1'b0;
      tick();
    end
    rst = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
